// File: rtl/comparador_serial_izq_der.sv
// ---------------------------------------------------------------------------
// comparador_serial_izq_der
// Bit-serial unsigned magnitude comparator scanning MSB to LSB, one bit per
// clock. Operands are captured when a request is accepted, so later changes
// on A/B do not disturb a comparison in progress.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   start  in   compare request, only looked at in IDLE
//   A, B   in   N-bit unsigned operands (bit N-1 is the MSB)
//   busy   out  high while comparing
//   done   out  one-cycle pulse, result valid
//   mayor  out  A > B
//   igual  out  A == B
//   menor  out  A < B
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for start; result flags hold the last outcome
// ST_COMPARE | checking captured bit idx, moving towards the LSB
// ST_DONE    | result just resolved; done is high for this one cycle
// ---------------------------------------------------------------------------
module comparador_serial_izq_der #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic         mayor,
    output logic         igual,
    output logic         menor
);

    // Index is at least one bit wide so N=1 still has a legal counter.
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic [N-1:0]   a_nxt;
    logic [N-1:0]   b_nxt;
    logic [IW-1:0]  idx;
    logic [IW-1:0]  idx_nxt;
    logic           bit_a;
    logic           bit_b;
    logic           idx_last;
    logic           busy_nxt;
    logic           done_nxt;
    logic           mayor_nxt;
    logic           igual_nxt;
    logic           menor_nxt;

    assign bit_a    = a_q[idx];
    assign bit_b    = b_q[idx];
    assign idx_last = (idx == '0);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if ((bit_a != bit_b) || idx_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output / datapath next values; everything is registered below so the
    // outputs are glitch-free and aligned with the state register.
    always_comb begin
        a_nxt     = a_q;
        b_nxt     = b_q;
        idx_nxt   = idx;
        mayor_nxt = mayor;
        igual_nxt = igual;
        menor_nxt = menor;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    a_nxt     = A;
                    b_nxt     = B;
                    idx_nxt   = IW'(N - 1);
                    mayor_nxt = 1'b0;
                    igual_nxt = 1'b0;
                    menor_nxt = 1'b0;
                end
            end
            ST_COMPARE: begin
                if (bit_a != bit_b) begin
                    mayor_nxt = bit_a;
                    menor_nxt = ~bit_a;
                end else if (idx_last) begin
                    igual_nxt = 1'b1;
                end else begin
                    // Only reached with idx > 0, so this never wraps.
                    idx_nxt = idx - IW'(1);
                end
            end
            default: begin
            end
        endcase
        busy_nxt = (state_nxt == ST_COMPARE);
        done_nxt = (state_nxt == ST_DONE);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            mayor <= 1'b0;
            igual <= 1'b0;
            menor <= 1'b0;
        end else begin
            a_q   <= a_nxt;
            b_q   <= b_nxt;
            idx   <= idx_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            mayor <= mayor_nxt;
            igual <= igual_nxt;
            menor <= menor_nxt;
        end
    end

endmodule

// File: doc/comparador_serial_izq_der.md
COMPARADOR_SERIAL_IZQ_DER -- requirements
Module: comparador_serial_izq_der

Interface
REQ-001 Parameter: N, default 8, operand width in bits; legal range N >= 1.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 start  input  1  request to compare A and B; sampled only in IDLE.
REQ-005 A  input  N  first operand; bit N-1 is the MSB.
REQ-006 B  input  N  second operand; bit N-1 is the MSB.
REQ-007 busy  output  1  high while in COMPARE.
REQ-008 done  output  1  one-cycle pulse: result valid.
REQ-009 mayor  output  1  result: A > B, unsigned.
REQ-010 igual  output  1  result: A == B.
REQ-011 menor  output  1  result: A < B, unsigned.

Function
REQ-012 The block SHALL implement a bit-serial unsigned magnitude comparator that scans from left to right: MSB first, one bit per clock.
REQ-013 The FSM SHALL have three states: IDLE, COMPARE and DONE. All outputs SHALL be registered.
REQ-014 In IDLE with start=1 at an edge, the block SHALL capture A and B into internal registers, set the bit index to N-1, clear mayor, igual and menor, and enter COMPARE.
REQ-015 In COMPARE, each edge SHALL evaluate captured bit A[idx] against B[idx]:
- bits differ: set mayor=1 if A[idx]=1, otherwise set menor=1, and enter DONE.
- bits equal and idx=0: set igual=1 and enter DONE.
- otherwise: decrement idx and remain in COMPARE.
REQ-016 Latency: with start captured at edge k, the first differing bit at position i SHALL be resolved at edge k+(N-i). Equal operands SHALL be resolved at edge k+N. done SHALL be high for exactly the one cycle following the resolving edge.
REQ-017 From DONE, the next edge SHALL return the FSM to IDLE and clear done. mayor, igual and menor SHALL then hold until the next start is accepted.
REQ-018 After completion, exactly one of mayor, igual and menor SHALL be high (one-hot).
REQ-019 start SHALL be ignored in COMPARE and in DONE. No queuing of requests.
REQ-020 Changes on A or B after capture SHALL NOT affect the result in progress.
REQ-021 A start asserted in the first IDLE cycle after DONE SHALL be accepted, giving back-to-back operation.
REQ-022 N=1 SHALL resolve in one COMPARE edge. The idx counter SHALL be at least 1 bit wide and SHALL never underflow.

Reset
REQ-023 When rst_n=0 at an edge, the block SHALL enter IDLE and force busy=0, done=0, mayor=0, igual=0 and menor=0. This applies in any state, including mid-comparison.
REQ-024 After reset, flags SHALL stay 0 until the first comparison completes. An in-progress comparison SHALL be discarded with no done pulse.

Verification (N=4)
REQ-025 A=1010, B=1001, start pulse -> busy for 3 cycles; done pulse; mayor=1, igual=0, menor=0.
REQ-026 A=0111, B=1000 -> resolved at the first compare edge; done in the next cycle; menor=1.
REQ-027 A=B=0101 -> 4 compare cycles, then done; igual=1. Repeat with A=B=0000 and with A=B=1111, giving the same result.
REQ-028 Start held high through COMPARE, and A/B changed during COMPARE -> only one comparison runs, with one done pulse; the result matches the captured operands. A new start in the cycle after DONE is accepted.
REQ-029 rst_n=0 during the 2nd COMPARE cycle -> the next cycle shows all outputs 0 and FSM in IDLE; no done pulse. A subsequent A=0011, B=0010 comparison returns mayor.
REQ-030 Exhaustive sweep of all 256 A/B pairs -> each result is one-hot, matches the unsigned comparison, and its latency matches REQ-016.
